// File: rtl/fifo_buffer_pkg.sv
// Shared types for the FWFT byte FIFO: per-edge operation code and its decode helper.
package fifo_buffer_pkg;

  typedef enum logic [1:0] {
    OP_HOLD = 2'b00,
    OP_PUSH = 2'b01,
    OP_POP  = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

  function automatic fifo_op_e decode_op(input logic push, input logic pop);
    return fifo_op_e'({pop, push});
  endfunction

endpackage

// File: rtl/fifo_ctrl.sv
// Pointer/count/flag controller for the FWFT FIFO; flags update on the same edge as the pointers.
// A write while full is accepted only when a pop frees the slot in that same cycle.
module fifo_ctrl
  import fifo_buffer_pkg::*;
#(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr,
  input  logic                  rd,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH-1:0] raddr,
  output logic                  empty,
  output logic                  full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);

  logic [ADDR_WIDTH-1:0] wptr;
  logic [ADDR_WIDTH-1:0] rptr;
  logic [ADDR_WIDTH:0]   count_next;
  logic                  push;
  logic                  pop;
  fifo_op_e              op;

  always_comb begin
    push       = wr & (~full | rd);
    pop        = rd & ~empty;
    op         = decode_op(push, pop);
    count_next = count;
    case (op)
      OP_PUSH: count_next = count + 1'b1;
      OP_POP:  count_next = count - 1'b1;
      OP_HOLD,
      OP_BOTH: count_next = count;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr      <= '0;
      rptr      <= '0;
      count     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      // Pointers wrap naturally at the power-of-two depth.
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count_next;
      empty <= (count_next == '0);
      full  <= (count_next == DEPTH_CNT);
      if (wr & full & ~rd) overflow  <= 1'b1;
      if (rd & empty)      underflow <= 1'b1;
    end
  end

  assign we    = push;
  assign waddr = wptr;
  assign raddr = rptr;

endmodule

// File: rtl/fifo_buffer.sv
// First-word-fall-through byte FIFO: head visible combinationally from registered state (0-cycle read).
// Writes when full are dropped (sticky o_overflow) unless paired with a pop; reads when empty set o_underflow.
module fifo_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_wr,
  input  logic [DATA_WIDTH-1:0] i_w_data,
  input  logic                  i_rd,
  output logic [DATA_WIDTH-1:0] o_r_data,
  output logic                  o_empty,
  output logic                  o_full,
  output logic [ADDR_WIDTH:0]   o_count,
  output logic                  o_overflow,
  output logic                  o_underflow
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic                  we;
  logic [ADDR_WIDTH-1:0] waddr;
  logic [ADDR_WIDTH-1:0] raddr;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  fifo_ctrl #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_ctrl (
    .clock    (i_clock),
    .reset    (i_reset),
    .wr       (i_wr),
    .rd       (i_rd),
    .we       (we),
    .waddr    (waddr),
    .raddr    (raddr),
    .empty    (o_empty),
    .full     (o_full),
    .count    (o_count),
    .overflow (o_overflow),
    .underflow(o_underflow)
  );

  // Storage is intentionally not reset; the head is don't-care while empty.
  always_ff @(posedge i_clock) begin
    if (we) mem[waddr] <= i_w_data;
  end

  assign o_r_data = mem[raddr];

endmodule

// File: tb/tb_fifo_buffer.sv
// Directed bench for fifo_buffer (depth 4) with a queue-based reference model checked every cycle.
module tb_fifo_buffer;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr = 1'b0;
  logic          rd = 1'b0;
  logic [DW-1:0] w_data = '0;
  logic [DW-1:0] r_data;
  logic          empty;
  logic          full;
  logic [AW:0]   count;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q[$];
  logic [DW-1:0] popped[$];
  logic          m_ovf = 1'b0;
  logic          m_udf = 1'b0;

  fifo_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .i_clock    (clk),
    .i_reset    (rst_n),
    .i_wr       (wr),
    .i_w_data   (w_data),
    .i_rd       (rd),
    .o_r_data   (r_data),
    .o_empty    (empty),
    .o_full     (full),
    .o_count    (count),
    .o_overflow (overflow),
    .o_underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a queue of stored words and two sticky bits.
  always @(negedge rst_n) begin
    model_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n) begin
      automatic bit was_empty = (model_q.size() == 0);
      automatic bit was_full  = (model_q.size() == DEPTH);
      if (rd && was_empty) m_udf = 1'b1;
      if (wr && was_full && !rd) m_ovf = 1'b1;
      if (rd && !was_empty) popped.push_back(model_q.pop_front());
      if (wr && (!was_full || rd)) model_q.push_back(w_data);
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("m_empty", 32'(empty), 32'(model_q.size() == 0));
      check("m_full", 32'(full), 32'(model_q.size() == DEPTH));
      check("m_count", 32'(count), 32'(model_q.size()));
      check("m_ovf", 32'(overflow), 32'(m_ovf));
      check("m_udf", 32'(underflow), 32'(m_udf));
      if (model_q.size() != 0) check("m_head", 32'(r_data), 32'(model_q[0]));
    end
  end

  task automatic op(input logic w, input logic [DW-1:0] d, input logic r);
    @(negedge clk);
    #1;
    wr = w;
    w_data = d;
    rd = r;
    @(posedge clk);
    #1;
    wr = 1'b0;
    rd = 1'b0;
    w_data = '0;
  endtask

  task automatic sync_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [DW-1:0] fill_a [4];
    fill_a = '{8'h11, 8'h22, 8'h33, 8'h44};

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_full", 32'(full), 32'd0);
    check("idle_count", 32'(count), 32'd0);
    check("idle_ovf", 32'(overflow), 32'd0);
    check("idle_udf", 32'(underflow), 32'd0);

    // Fill
    for (int i = 0; i < 4; i++) op(1'b1, fill_a[i], 1'b0);
    check("fill_full", 32'(full), 32'd1);
    check("fill_count", 32'(count), 32'd4);
    check("fill_head", 32'(r_data), 32'h11);

    // Overflow while full
    op(1'b1, 8'h55, 1'b0);
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(count), 32'd4);

    // Drain, checking the head just before each pop
    for (int i = 0; i < 4; i++) begin
      check("drain_head", 32'(r_data), 32'(fill_a[i]));
      op(1'b0, 8'h00, 1'b1);
    end
    check("drain_empty", 32'(empty), 32'd1);

    // Simultaneous rd/wr while empty
    op(1'b1, 8'hA5, 1'b1);
    check("rwe_count", 32'(count), 32'd1);
    check("rwe_head", 32'(r_data), 32'hA5);
    check("rwe_udf", 32'(underflow), 32'd1);
    op(1'b0, 8'h00, 1'b1);

    // Simultaneous rd/wr while full, wrapping pointers
    sync_reset();
    for (int i = 1; i <= 4; i++) op(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      check("rwf_head", 32'(r_data), 32'(i + 1));
      op(1'b1, 8'(i + 5), 1'b1);
      check("rwf_full", 32'(full), 32'd1);
    end
    check("rwf_ovf", 32'(overflow), 32'd0);
    check("rwf_next", 32'(r_data), 32'h07);

    // Async reset mid-stream with 3 words stored
    op(1'b0, 8'h00, 1'b1);
    check("pre_count", 32'(count), 32'd3);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_empty", 32'(empty), 32'd1);
    check("arst_count", 32'(count), 32'd0);
    #1;
    rst_n = 1'b1;
    op(1'b1, 8'h77, 1'b0);
    check("post_head", 32'(r_data), 32'h77);
    check("post_count", 32'(count), 32'd1);

    repeat (2) @(posedge clk);
    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_buffer.md
Name: fifo_buffer

Overview:
- Synchronous first-word-fall-through (FWFT) FIFO that buffers bytes between the UART and the ALU interface FSM.
- Two instances are used:
  - RX side: UART receiver writes; the interface FSM reads operand A, operand B and opcode.
  - TX side: the interface FSM writes the result; the UART transmitter reads.
- The FIFO head is always visible on o_r_data, so a consumer can sample the data and assert i_rd in the same cycle.

Parameters:
- DATA_WIDTH, 8, width of each stored word.
- ADDR_WIDTH, 4, pointer width; depth = 2**ADDR_WIDTH (default 16 words).

Ports:
- i_clock  input  1  system clock; all state updates on the rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_wr  input  1  write request; pushes i_w_data at the clock edge.
- i_w_data  input  DATA_WIDTH  data to push.
- i_rd  input  1  read request; pops the head at the clock edge.
- o_r_data  output  DATA_WIDTH  current head word (FWFT); valid only while o_empty=0.
- o_empty  output  1  FIFO holds 0 words.
- o_full  output  1  FIFO holds 2**ADDR_WIDTH words.
- o_count  output  ADDR_WIDTH+1  number of stored words, 0..2**ADDR_WIDTH.
- o_overflow  output  1  sticky; set when a write is dropped.
- o_underflow  output  1  sticky; set when a read is requested while empty.

Behaviour:
- Reset:
  - Asserting i_reset low clears the FIFO immediately, asynchronously to the clock: write pointer=0, read pointer=0, o_count=0, o_empty=1, o_full=0, o_overflow=0, o_underflow=0.
  - Storage array contents are not reset. o_r_data is don't-care while empty.
  - Reset in the middle of traffic discards all stored words. Release is synchronous to the next rising edge.
- Storage and read path:
  - Storage is a DATA_WIDTH x 2**ADDR_WIDTH register array, written at the clock edge.
  - o_r_data = mem[read pointer], combinational from registered state. Read latency is 0 cycles: the head is visible in the cycle before the pop.
- Write-to-read latency: a word written at edge N is visible on o_r_data and clears o_empty after edge N, i.e. in cycle N+1.
- Pointers: ADDR_WIDTH bits each, incremented modulo depth; wrap from 2**ADDR_WIDTH-1 to 0 with no special case.
- Flags: o_empty, o_full and o_count are registered and updated at the same edge as the pointers. No combinational path from i_rd/i_wr to any output.
- Operations per edge (E=o_empty, F=o_full):
  - wr only, F=0: store word, wptr+1, count+1, clear empty; set full if count reaches depth.
  - wr only, F=1: drop write; state unchanged; set o_overflow.
  - rd only, E=0: rptr+1, count-1, clear full; set empty if count reaches 0.
  - rd only, E=1: ignored; set o_underflow.
  - rd and wr, E=0, F=0: both performed; count and flags unchanged.
  - rd and wr, F=1: both performed, because the pop frees a slot. count stays at depth, full stays 1, no overflow.
  - rd and wr, E=1: write performed, read ignored. count=1, empty clears. o_underflow is set.
  - neither: hold.
- Sticky flags: o_overflow and o_underflow clear only on reset.
- Count invariants:
  - o_count never exceeds depth and never goes below 0.
  - o_empty == (o_count==0).
  - o_full == (o_count==depth).

Decomposition:
- No shared package is required. Depth derivation (2**ADDR_WIDTH) is a localparam inside the module.
- One natural sub-module: fifo_ctrl. It owns the pointers, the count, the empty/full/sticky flags and the accept logic, and outputs write enable, write address and read address.
- fifo_buffer instantiates fifo_ctrl and the register array.

Test Plan (ADDR_WIDTH=2, depth 4, DATA_WIDTH=8):
- Reset then idle:
  - Stimulus: hold i_reset low, then release.
  - Required: o_empty=1, o_full=0, o_count=0, both sticky flags 0.
- Fill and drain:
  - Stimulus: write 0x11, 0x22, 0x33, 0x44 on consecutive cycles.
  - Required: o_full=1, o_count=4, o_r_data=0x11.
  - Stimulus: read 4 times.
  - Required: o_r_data sequence is 0x11, 0x22, 0x33, 0x44; o_empty=1 after the 4th pop.
- Overflow:
  - Stimulus: while full, write 0x55.
  - Required: o_overflow=1, o_count=4, and the drained sequence remains 0x11..0x44.
- Underflow, and simultaneous rd/wr while empty:
  - Stimulus: rd with wr of 0xA5 while empty.
  - Required: o_count=1, o_r_data=0xA5, o_underflow=1.
- Simultaneous rd/wr while full, with wrap:
  - Stimulus: fill with 0x01..0x04, then do 6 cycles of rd+wr with data 0x05..0x0A.
  - Required: o_full=1 throughout, no overflow, popped data 0x01..0x06, remaining head 0x07.
- Asynchronous reset mid-stream:
  - Stimulus: with 3 words stored, pulse i_reset low between clock edges.
  - Required: o_empty=1 and o_count=0 immediately, before any clock edge; subsequent write 0x77 reads back 0x77.
